// File: rtl/led_pattern_sequencer.sv
// Four-effect LED pattern scheduler (fill, drain, rotate-pair, blink) paced by a tick prescaler.
// Build option LED_ACTIVE_LOW_EN: led drives the inverted pattern for sink-driven boards.
//
// mode  | meaning
// FILL  | LSB-first fill to all-ones, one LED per step
// DRAIN | all-ones drained from the LSB, one LED per step
// ROT2  | adjacent pair rotating left, one position per step
// BLINK | all-on on even steps, all-off on odd steps
module led_pattern_sequencer #(
   parameter int WIDTH  = 8,
   parameter int DIV    = 4,
   parameter int REPEAT = 2
) (
   input  logic             clk,
   input  logic             rs,
   input  logic             en,
   input  logic             mode_ld,
   input  logic [1:0]       mode_in,
   output logic [WIDTH-1:0] led,
   output logic [1:0]       mode,
   output logic             tick,
   output logic             cycle_done
);

   localparam int SW  = $clog2(WIDTH);
   localparam int PSW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef LED_ACTIVE_LOW_EN
   localparam logic [WIDTH-1:0] LED_OFF = '1;
`else
   localparam logic [WIDTH-1:0] LED_OFF = '0;
`endif

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      DRAIN = 2'd1,
      ROT2  = 2'd2,
      BLINK = 2'd3
   } mode_t;

   mode_t            mode_q;
   logic [SW-1:0]    step_q;
   logic [PSW-1:0]   pass_q;
   logic [PW-1:0]    presc_q;
   logic [WIDTH-1:0] led_q;
   logic             tick_q;
   logic             done_q;

   logic tick_ev;
   logic step_last;
   logic pass_last;

   // Pattern shown at step k; rotation wraps by subtraction so no shift goes out of range.
   function automatic logic [WIDTH-1:0] pattern(input mode_t m, input logic [SW-1:0] k);
      logic [WIDTH-1:0] p;
      int kk;
      int r0;
      int r1;
      p  = '0;
      kk = int'(k);
      r0 = (kk + 1 >= WIDTH) ? kk + 1 - WIDTH : kk + 1;
      r1 = (kk + 2 >= WIDTH) ? kk + 2 - WIDTH : kk + 2;
      for (int i = 0; i < WIDTH; i++) begin
         case (m)
            FILL:    p[i] = (i <= kk);
            DRAIN:   p[i] = (i > kk);
            ROT2:    p[i] = (i == r0) || (i == r1);
            BLINK:   p[i] = ~k[0];
            default: p[i] = 1'b0;
         endcase
      end
      return p;
   endfunction

   assign tick_ev   = (presc_q == PW'(DIV - 1));
   assign step_last = (step_q == SW'(WIDTH - 1));
   assign pass_last = (pass_q == PSW'(REPEAT - 1));

   always_ff @(posedge clk) begin
      if (!rs) begin
         mode_q  <= FILL;
         step_q  <= '0;
         pass_q  <= '0;
         presc_q <= '0;
         led_q   <= LED_OFF;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (mode_ld) begin
         mode_q  <= mode_t'(mode_in);
         step_q  <= '0;
         pass_q  <= '0;
         presc_q <= '0;
         led_q   <= LED_OFF;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (!en) begin
         tick_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         tick_q <= tick_ev;
         done_q <= 1'b0;
         if (tick_ev) begin
            presc_q <= '0;
            led_q   <= pattern(mode_q, step_q) ^ LED_OFF;
            if (step_last) begin
               step_q <= '0;
               if (pass_last) begin
                  // mode advances on the same edge as the final-step led update
                  pass_q <= '0;
                  mode_q <= mode_t'(mode_q + 2'd1);
                  done_q <= (mode_q == BLINK);
               end else begin
                  pass_q <= pass_q + PSW'(1);
               end
            end else begin
               step_q <= step_q + SW'(1);
            end
         end else begin
            presc_q <= presc_q + PW'(1);
         end
      end
   end

   assign led        = led_q;
   assign mode       = mode_q;
   assign tick       = tick_q;
   assign cycle_done = done_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: a tick-count reference model queues expected
// outputs per edge and a negedge monitor pops and compares them.
module tb_led_pattern_sequencer;

   localparam int WIDTH  = 8;
   localparam int DIV    = 4;
   localparam int REPEAT = 2;
   localparam int PER    = REPEAT * WIDTH;

`ifdef LED_ACTIVE_LOW_EN
   localparam logic [WIDTH-1:0] OFF = '1;
`else
   localparam logic [WIDTH-1:0] OFF = '0;
`endif

   logic             clk = 1'b0;
   logic             rs = 1'b0;
   logic             en = 1'b0;
   logic             mode_ld = 1'b0;
   logic [1:0]       mode_in = 2'd0;
   logic [WIDTH-1:0] led;
   logic [1:0]       mode;
   logic             tick;
   logic             cycle_done;

   led_pattern_sequencer #(.WIDTH(WIDTH), .DIV(DIV), .REPEAT(REPEAT)) dut (
      .clk(clk), .rs(rs), .en(en), .mode_ld(mode_ld), .mode_in(mode_in),
      .led(led), .mode(mode), .tick(tick), .cycle_done(cycle_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] led;
      logic [1:0]       mode;
      logic             tick;
      logic             cd;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // reference state: effect loaded at last reset/load, enabled edges since then
   int   base_mode = 0;
   int   ec = 0;
   exp_t m;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_pat(input int eff, input int k);
      longint unsigned all;
      longint unsigned r;
      all = (64'd1 << WIDTH) - 64'd1;
      case (eff)
         0: return WIDTH'((64'd1 << (k + 1)) - 64'd1);
         1: return WIDTH'((all << (k + 1)) & all);
         2: begin
            r = 64'd3 << ((k + 1) % WIDTH);
            return WIDTH'((r | (r >> WIDTH)) & all);
         end
         default: return (k % 2 == 0) ? WIDTH'(all) : '0;
      endcase
   endfunction

   // apply inputs for one edge, queue the model's prediction, advance past the edge
   task automatic drive(input logic r, input logic e, input logic l, input logic [1:0] mi);
      int t;
      int eff;
      rs = r; en = e; mode_ld = l; mode_in = mi;
      if (!r) begin
         base_mode = 0; ec = 0;
         m = '{led: OFF, mode: 2'd0, tick: 1'b0, cd: 1'b0};
      end else if (l) begin
         base_mode = int'(mi); ec = 0;
         m = '{led: OFF, mode: mi, tick: 1'b0, cd: 1'b0};
      end else if (!e) begin
         m.tick = 1'b0; m.cd = 1'b0;
      end else begin
         ec++;
         if (ec % DIV == 0) begin
            t      = ec / DIV - 1;
            eff    = (base_mode + t / PER) % 4;
            m.led  = ref_pat(eff, t % WIDTH) ^ OFF;
            m.mode = 2'((base_mode + (t + 1) / PER) % 4);
            m.tick = 1'b1;
            m.cd   = ((t + 1) % PER == 0) && (eff == 3);
         end else begin
            m.tick = 1'b0; m.cd = 1'b0;
         end
      end
      q.push_back(m);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t ex;
      if (q.size() > 0) begin
         ex = q.pop_front();
         cmp("led", 32'(led), 32'(ex.led));
         cmp("mode", 32'(mode), 32'(ex.mode));
         cmp("tick", 32'(tick), 32'(ex.tick));
         cmp("cycle_done", 32'(cycle_done), 32'(ex.cd));
      end
   end

   initial begin
      logic [1:0] rmi;
      // reset dominates en and mode_ld
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 2'd3);

      // one full cycle from reset release with fixed-point spot checks
      for (int e = 1; e <= 256; e++) begin
         drive(1'b1, 1'b1, 1'b0, 2'd0);
         if (e == 4)   begin cmp("e4_led", 32'(led), 32'(8'h01 ^ OFF)); cmp("e4_tick", 32'(tick), 32'd1); end
         if (e == 8)   cmp("e8_led", 32'(led), 32'(8'h03 ^ OFF));
         if (e == 32)  cmp("e32_led", 32'(led), 32'(8'hFF ^ OFF));
         if (e == 36)  cmp("e36_led", 32'(led), 32'(8'h01 ^ OFF));
         if (e == 64)  begin cmp("e64_mode", 32'(mode), 32'd1); cmp("e64_led", 32'(led), 32'(8'hFF ^ OFF)); end
         if (e == 68)  cmp("e68_led", 32'(led), 32'(8'hFE ^ OFF));
         if (e == 128) cmp("e128_mode", 32'(mode), 32'd2);
         if (e == 132) cmp("e132_led", 32'(led), 32'(8'h06 ^ OFF));
         if (e == 192) cmp("e192_mode", 32'(mode), 32'd3);
         if (e == 256) begin
            cmp("e256_cd", 32'(cycle_done), 32'd1);
            cmp("e256_mode", 32'(mode), 32'd0);
            cmp("e256_led", 32'(led), 32'(8'h00 ^ OFF));
         end
      end

      // reach led=07 in FILL, then freeze mid-prescaler
      for (int i = 0; i < 14; i++) drive(1'b1, 1'b1, 1'b0, 2'd0);
      cmp("frz_led", 32'(led), 32'(8'h07 ^ OFF));
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 2'd0);
      cmp("frz_hold", 32'(led), 32'(8'h07 ^ OFF));
      drive(1'b1, 1'b1, 1'b0, 2'd0);
      drive(1'b1, 1'b1, 1'b0, 2'd0);
      cmp("resume_led", 32'(led), 32'(8'h0F ^ OFF));

      // mode_ld on an edge that would have ticked
      while ((ec + 1) % DIV != 0) drive(1'b1, 1'b1, 1'b0, 2'd0);
      drive(1'b1, 1'b1, 1'b1, 2'd2);
      cmp("ld_tick", 32'(tick), 32'd0);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 2'd0);
      cmp("ld_led", 32'(led), 32'(8'h06 ^ OFF));

      // reset during ROT2, then restart
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 2'd0);
      drive(1'b0, 1'b1, 1'b0, 2'd0);
      cmp("rst_mode", 32'(mode), 32'd0);
      for (int i = 0; i < 70; i++) drive(1'b1, 1'b1, 1'b0, 2'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rmi = 2'($urandom_range(0, 3));
         drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 4) != 0),
               ($urandom_range(0, 49) == 0), rmi);
      end

      @(negedge clk);
      #1;
      cmp("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
